// File: rtl/alu_pipe_mul.sv
// ============================================================================
// alu_pipe_mul : registered ALU (13 ops) plus iterative shift-add MUL/MULH
//   on valid/ready handshakes. Optional macro ALU_OVF_EN adds out_ovf.
// Revision: 1.0 initial release
// ============================================================================
`default_nettype none

module alu_pipe_mul #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
`ifdef ALU_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_MUL  = 2'd1;
  localparam logic [1:0] C_HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               neg_q;
  logic               hi_q;
  logic [WIDTH-1:0]   result_q;
  logic [TAG_W-1:0]   tag_q;

  logic               w_accept;
  logic               w_is_mul;
  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_add, w_sub, w_alu;
  logic [WIDTH-1:0]   w_mag1, w_mag2;
  logic [WIDTH:0]     w_step_sum;
  logic [2*WIDTH-1:0] w_prod_nx, w_full;

  assign w_accept = in_valid & in_ready;
  assign w_is_mul = (in_op == 4'd14) || (in_op == 4'd15);
  assign w_shamt  = in_src1[SHW-1:0];
  assign w_add    = in_src1 + in_src2;
  assign w_sub    = in_src1 - in_src2;
  assign w_mag1   = in_src1[WIDTH-1] ? -in_src1 : in_src1;
  assign w_mag2   = in_src2[WIDTH-1] ? -in_src2 : in_src2;

  always_comb begin
    w_alu = '0;
    case (in_op)
      4'd1:    w_alu = w_add;
      4'd2:    w_alu = w_sub;
      4'd3:    w_alu = {{(WIDTH-1){1'b0}}, ($signed(in_src1) < $signed(in_src2))};
      4'd4:    w_alu = {{(WIDTH-1){1'b0}}, (in_src1 < in_src2)};
      4'd5:    w_alu = in_src1 & in_src2;
      4'd6:    w_alu = ~(in_src1 | in_src2);
      4'd7:    w_alu = in_src1 | in_src2;
      4'd8:    w_alu = in_src1 ^ in_src2;
      4'd9:    w_alu = in_src2 << w_shamt;
      4'd10:   w_alu = in_src2 >> w_shamt;
      4'd11:   w_alu = $signed(in_src2) >>> w_shamt;
      4'd12:   w_alu = {in_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'd13:   w_alu = ~(in_src1 ^ in_src2);
      default: w_alu = '0;
    endcase
  end

  // One shift-add step: low half of prod_q holds the remaining multiplier bits.
  assign w_step_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : {WIDTH{1'b0}})};
  assign w_prod_nx  = {w_step_sum, prod_q[WIDTH-1:1]};
  assign w_full     = neg_q ? -w_prod_nx : w_prod_nx;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= C_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (in_valid) state_d = w_is_mul ? C_MUL : C_HOLD;
      C_MUL:   if (cnt_q == '0) state_d = C_HOLD;
      C_HOLD:  if (out_ready) state_d = in_valid ? (w_is_mul ? C_MUL : C_HOLD) : C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == C_IDLE) || ((state_q == C_HOLD) && out_ready);
    busy      = (state_q == C_MUL);
    out_valid = (state_q == C_HOLD);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (w_accept) begin
      tag_q <= in_tag;
      if (w_is_mul) begin
        mcand_q <= w_mag1;
        prod_q  <= {{WIDTH{1'b0}}, w_mag2};
        neg_q   <= in_src1[WIDTH-1] ^ in_src2[WIDTH-1];
        hi_q    <= in_op[0];
        cnt_q   <= SHW'(WIDTH-1);
      end else begin
        result_q <= w_alu;
      end
    end else if (state_q == C_MUL) begin
      prod_q <= w_prod_nx;
      if (cnt_q == '0) result_q <= hi_q ? w_full[2*WIDTH-1:WIDTH] : w_full[WIDTH-1:0];
      else             cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign out_result = result_q;
  assign out_tag    = tag_q;

`ifdef ALU_OVF_EN
  logic ovf_q;
  logic w_ovf;

  always_comb begin
    w_ovf = 1'b0;
    if (in_op == 4'd1)
      w_ovf = (in_src1[WIDTH-1] == in_src2[WIDTH-1]) && (w_add[WIDTH-1] != in_src1[WIDTH-1]);
    else if (in_op == 4'd2)
      w_ovf = (in_src1[WIDTH-1] != in_src2[WIDTH-1]) && (w_sub[WIDTH-1] != in_src1[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                            ovf_q <= 1'b0;
    else if (w_accept)                      ovf_q <= w_is_mul ? 1'b0 : w_ovf;
    else if (state_q == C_MUL && cnt_q == '0) ovf_q <= 1'b0;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe_mul.sv
// Scoreboard bench for alu_pipe_mul: directed vectors, queue-based monitor.
`default_nettype none

module tb_alu_pipe_mul;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_src1, in_src2;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        busy;
  logic        out_ovf;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  alu_pipe_mul #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .busy      (busy)
`ifdef ALU_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

`ifndef ALU_OVF_EN
  assign out_ovf = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // lat: cycles from accept edge to out_valid; negative skips the timing check
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] tag, input logic [31:0] res, input logic ovf,
                       input int lat);
    exp_t e;
    int   n;
    in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout op=%0d got in_ready=0 expected 1", op);
        in_valid = 1'b0;
        return;
      end
    end
    e.res = res; e.tag = tag; e.ovf = ovf;
    e.cyc = (lat < 0) ? -1 : cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resetn && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output got=%h/t%0d expected no output", out_result, out_tag);
      end else begin
        e = sb.pop_front();
        if (out_result !== e.res || out_tag !== e.tag) begin
          failures++;
          $display("FAIL result got=%h/t%0d expected=%h/t%0d", out_result, out_tag, e.res, e.tag);
        end
        if (e.cyc >= 0) begin
          checks++;
          if (cyc != e.cyc) begin
            failures++;
            $display("FAIL latency tag%0d got cycle=%0d expected=%0d", e.tag, cyc, e.cyc);
          end
        end
`ifdef ALU_OVF_EN
        checks++;
        if (out_ovf !== e.ovf) begin
          failures++;
          $display("FAIL ovf tag%0d got=%b expected=%b", e.tag, out_ovf, e.ovf);
        end
`endif
      end
    end
  end

  initial begin
    int n;
    logic ok;
    resetn = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0;
    in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {28'b0, out_tag}, 32'd0);
    chk("rst_ovf", {31'b0, out_ovf}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;

    // back-to-back simple ops, one result per cycle
    issue(4'd1, 32'd5, 32'd7, 4'd1, 32'd12, 1'b0, 0);
    issue(4'd2, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE, 1'b0, 0);
    issue(4'd11, 32'd4, 32'h8000_0000, 4'd3, 32'hF800_0000, 1'b0, 0);
    issue(4'd3, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1, 1'b0, 0);
    issue(4'd4, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0, 1'b0, 0);
    issue(4'd12, 32'hDEAD_BEEF, 32'h0000_1234, 4'd6, 32'h1234_0000, 1'b0, 0);
    issue(4'd13, 32'd0, 32'd0, 4'd7, 32'hFFFF_FFFF, 1'b0, 0);
    issue(4'd9, 32'd33, 32'd1, 4'd8, 32'd2, 1'b0, 0);
    issue(4'd10, 32'd8, 32'h8000_0000, 4'd9, 32'h0080_0000, 1'b0, 0);
    issue(4'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd10, 32'h0F00_0F00, 1'b0, 0);
    issue(4'd6, 32'hF0F0_F0F0, 32'h0F0F_0000, 4'd11, 32'h0000_0F0F, 1'b0, 0);
    issue(4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd12, 32'hFFF0_FFF0, 1'b0, 0);
    issue(4'd8, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd13, 32'hF0F0_F0F0, 1'b0, 0);
    issue(4'd0, 32'h1234_5678, 32'h9ABC_DEF0, 4'd14, 32'd0, 1'b0, 0);

    // multiply: WIDTH-cycle latency, busy and no ready meanwhile
    issue(4'd14, 32'hFFFF_FFFD, 32'd7, 4'd1, 32'hFFFF_FFEB, 1'b0, 32);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!busy || in_ready || out_valid) ok = 1'b0;
    end
    chk("mul_busy_window", {31'b0, ok}, 32'd1);
    issue(4'd15, 32'h8000_0000, 32'h8000_0000, 4'd2, 32'h4000_0000, 1'b0, 32);
    issue(4'd15, 32'hFFFF_FFFD, 32'd7, 4'd3, 32'hFFFF_FFFF, 1'b0, 32);
    issue(4'd14, 32'd6, 32'd7, 4'd4, 32'd42, 1'b0, 32);

    // reset in the middle of a multiply
    issue(4'd14, 32'd9, 32'd9, 4'd5, 32'd81, 1'b0, 32);
    repeat (10) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    chk("midmul_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("midmul_rst_busy", {31'b0, busy}, 32'd0);
    chk("midmul_rst_result", out_result, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {30'b0, in_ready, out_valid}, 32'd2);

    // backpressure: result held, no accept, then drain+accept on one edge
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'd1, 32'd100, 32'd23, 4'd5, 32'd123, 1'b0, -1);
    in_op = 4'd8; in_src1 = 32'hFF; in_src2 = 32'h0F; in_tag = 4'd6; in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_result !== 32'd123 || out_tag !== 4'd5) ok = 1'b0;
    end
    chk("backpressure_hold", {31'b0, ok}, 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    issue(4'd8, 32'hFF, 32'h0F, 4'd6, 32'hF0, 1'b0, 0);

    // signed overflow on add/sub
    issue(4'd1, 32'h7FFF_FFFF, 32'd1, 4'd7, 32'h8000_0000, 1'b1, 0);
    issue(4'd2, 32'd0, 32'd1, 4'd8, 32'hFFFF_FFFF, 1'b0, 0);
    issue(4'd2, 32'h8000_0000, 32'd1, 4'd9, 32'h7FFF_FFFF, 1'b1, 0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
